// File: rtl/dense_engine_if.sv
// Bus between the dense layer sequencer and its weight/bias stores, the activation
// buffer and the downstream result sink.
interface dense_engine_if #(
   parameter int DATSIZE = 22,
   parameter int PARSIZE = 16
);
   // start is a one-cycle request honoured only while idle (no ready/ack, extra pulses
   // are dropped); out_valid is a one-cycle strobe with no backpressure, so the sink must
   // take out_idx/out_data on that cycle.
   logic                       start;
   logic [3:0]                 state;
   logic                       relu;
   logic                       w_en;
   logic [6:0]                 read_o;
   logic [7:0]                 read_i;
   logic signed [PARSIZE-1:0]  weight;
   logic signed [PARSIZE-1:0]  bias;
   logic [7:0]                 act_addr;
   logic signed [DATSIZE-1:0]  act_data;
   logic                       out_valid;
   logic [6:0]                 out_idx;
   logic signed [DATSIZE-1:0]  out_data;
   logic                       busy;
   logic                       done;

   modport master (
      input  start, state, relu, weight, bias, act_data,
      output w_en, read_o, read_i, act_addr, out_valid, out_idx, out_data, busy, done
   );

   modport slave (
      output start, state, relu, weight, bias, act_data,
      input  w_en, read_o, read_i, act_addr, out_valid, out_idx, out_data, busy, done
   );
endinterface

// File: rtl/dense_engine.sv
// Sequencer and MAC for the fully-connected layers: walks every (neuron, input) pair,
// accumulates act*weight, adds bias, rescales, optional ReLU, saturates and emits.
module dense_engine #(
   parameter int DATSIZE = 22,
   parameter int PARSIZE = 16,
   parameter int FPSHIFT = 14,
   parameter int ACCSIZE = 48
) (
   input  logic             clk,
   input  logic             rst,
   dense_engine_if.master   bus,
   output logic [2:0]       fsm_state_o
);
   localparam int PRODSIZE = DATSIZE + PARSIZE;
   localparam logic [3:0] L_DENSE2 = 4'b1000;
   localparam logic [3:0] L_DENSE1 = 4'b1001;
   localparam logic [6:0] LAST_O   = 7'd95;
   localparam logic signed [ACCSIZE-1:0] SAT_MAX =
      {{(ACCSIZE-DATSIZE+1){1'b0}}, {(DATSIZE-1){1'b1}}};
   localparam logic signed [ACCSIZE-1:0] SAT_MIN =
      {{(ACCSIZE-DATSIZE+1){1'b1}}, {(DATSIZE-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_LAST, S_WRITE, S_FIN} fsm_t;

   fsm_t                        state_q, state_d;
   logic                        dense2_q, dense2_d;
   logic                        relu_q, relu_d;
   logic                        busy_q, busy_d;
   logic [6:0]                  o_q, o_d;
   logic [7:0]                  i_q, i_d;
   logic signed [ACCSIZE-1:0]   acc_q, acc_d;
   logic [6:0]                  out_idx_q, out_idx_d;
   logic signed [DATSIZE-1:0]   out_data_q, out_data_d;

   logic [7:0]                  last_i;
   logic signed [PRODSIZE-1:0]  act_ext, wgt_ext, prod;
   logic signed [ACCSIZE-1:0]   prod_ext, bias_sh, sum, scaled;
   logic signed [DATSIZE-1:0]   sat_val;

   assign fsm_state_o = state_q;
   assign last_i      = dense2_q ? 8'd255 : 8'd95;

   // Product of the pair issued one cycle earlier; the stores have one cycle of latency.
   assign act_ext  = {{(PRODSIZE-DATSIZE){bus.act_data[DATSIZE-1]}}, bus.act_data};
   assign wgt_ext  = {{(PRODSIZE-PARSIZE){bus.weight[PARSIZE-1]}}, bus.weight};
   assign prod     = act_ext * wgt_ext;
   assign prod_ext = {{(ACCSIZE-PRODSIZE){prod[PRODSIZE-1]}}, prod};
   assign bias_sh  = {{(ACCSIZE-PARSIZE){bus.bias[PARSIZE-1]}}, bus.bias} <<< FPSHIFT;

   always_comb begin
      sum    = acc_q + bias_sh;
      scaled = sum >>> FPSHIFT;
      if (relu_q && scaled[ACCSIZE-1]) begin
         scaled = '0;
      end
      if (scaled > SAT_MAX) begin
         sat_val = SAT_MAX[DATSIZE-1:0];
      end else if (scaled < SAT_MIN) begin
         sat_val = SAT_MIN[DATSIZE-1:0];
      end else begin
         sat_val = scaled[DATSIZE-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         dense2_q   <= 1'b0;
         relu_q     <= 1'b0;
         busy_q     <= 1'b0;
         o_q        <= '0;
         i_q        <= '0;
         acc_q      <= '0;
         out_idx_q  <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         dense2_q   <= dense2_d;
         relu_q     <= relu_d;
         busy_q     <= busy_d;
         o_q        <= o_d;
         i_q        <= i_d;
         acc_q      <= acc_d;
         out_idx_q  <= out_idx_d;
         out_data_q <= out_data_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      dense2_d      = dense2_q;
      relu_d        = relu_q;
      busy_d        = busy_q;
      o_d           = o_q;
      i_d           = i_q;
      acc_d         = acc_q;
      out_idx_d     = out_idx_q;
      out_data_d    = out_data_q;
      bus.w_en      = 1'b0;
      bus.read_o    = '0;
      bus.read_i    = '0;
      bus.act_addr  = '0;
      bus.out_valid = 1'b0;
      bus.out_idx   = out_idx_q;
      bus.out_data  = out_data_q;
      bus.busy      = busy_q;
      bus.done      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.state == L_DENSE2 || bus.state == L_DENSE1) begin
                  dense2_d = (bus.state == L_DENSE2);
                  relu_d   = bus.relu;
                  o_d      = '0;
                  i_d      = '0;
                  acc_d    = '0;
                  busy_d   = 1'b1;
                  state_d  = S_RUN;
               end else begin
                  state_d  = S_FIN;
               end
            end
         end
         S_RUN: begin
            bus.w_en     = 1'b1;
            bus.read_o   = o_q;
            bus.read_i   = i_q;
            bus.act_addr = i_q;
            // Nothing has been fetched yet on the first cycle of a neuron.
            if (i_q != 8'd0) begin
               acc_d = acc_q + prod_ext;
            end
            if (i_q == last_i) begin
               state_d = S_LAST;
            end else begin
               i_d = i_q + 8'd1;
            end
         end
         S_LAST: begin
            bus.read_o = o_q;
            acc_d      = acc_q + prod_ext;
            state_d    = S_WRITE;
         end
         S_WRITE: begin
            bus.read_o    = o_q;
            bus.out_valid = 1'b1;
            bus.out_idx   = o_q;
            bus.out_data  = sat_val;
            out_idx_d     = o_q;
            out_data_d    = sat_val;
            acc_d         = '0;
            i_d           = '0;
            if (o_q == LAST_O) begin
               state_d = S_FIN;
            end else begin
               o_d     = o_q + 7'd1;
               state_d = S_RUN;
            end
         end
         S_FIN: begin
            bus.done = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_dense_engine.sv
// Bench for dense_engine: store models, whole-layer reference model, cycle-exact
// sequencing checks and scripted plus random layer runs.
module tb_dense_engine;
   localparam int DATSIZE = 22;
   localparam int PARSIZE = 16;
   localparam int FPSHIFT = 14;
   localparam int ACCSIZE = 48;
   localparam longint OUT_MAX = 2097151;
   localparam longint OUT_MIN = -2097152;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] fsm_state;
   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dense_engine_if #(.DATSIZE(DATSIZE), .PARSIZE(PARSIZE)) dif ();

   dense_engine #(
      .DATSIZE(DATSIZE), .PARSIZE(PARSIZE), .FPSHIFT(FPSHIFT), .ACCSIZE(ACCSIZE)
   ) dut (
      .clk(clk), .rst(rst), .bus(dif), .fsm_state_o(fsm_state)
   );

   logic signed [DATSIZE-1:0] act_mem [256];
   logic signed [PARSIZE-1:0] w_mem   [96][256];
   logic signed [PARSIZE-1:0] b_mem   [96];

   // Store models: weight registered under w_en, activation registered, bias combinational.
   always @(posedge clk) begin
      if (dif.w_en) dif.weight <= w_mem[dif.read_o][dif.read_i];
      dif.act_data <= act_mem[dif.act_addr];
   end
   assign dif.bias = b_mem[dif.read_o];

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint ref_neuron(input int o, input int n_in, input bit rl);
      longint acc = 0;
      longint s;
      for (int i = 0; i < n_in; i++) acc += longint'(act_mem[i]) * longint'(w_mem[o][i]);
      acc += longint'(b_mem[o]) * (64'sd1 <<< FPSHIFT);
      s = acc >>> FPSHIFT;
      if (rl && s < 0) s = 0;
      if (s > OUT_MAX) s = OUT_MAX;
      if (s < OUT_MIN) s = OUT_MIN;
      return s;
   endfunction

   function automatic void fill(input int a, input int w, input int b);
      for (int i = 0; i < 256; i++) act_mem[i] = DATSIZE'(a);
      for (int o = 0; o < 96; o++) begin
         b_mem[o] = PARSIZE'(b);
         for (int i = 0; i < 256; i++) w_mem[o][i] = PARSIZE'(w);
      end
   endfunction

   // abort_off >= 0 fires an asynchronous reset that many cycles after the start edge.
   task automatic run_layer(input string name, input logic [3:0] st, input bit rl,
                            input int abort_off, input bit perturb);
      logic signed [DATSIZE-1:0] exp_q[$];
      bit   valid;
      int   n_in, done_off, n_strobe, seq_err, busy_err, done_err, k, p;
      bit   exp_wen, exp_ov, exp_busy;
      valid    = (st == 4'b1000) || (st == 4'b1001);
      n_in     = (st == 4'b1000) ? 256 : 96;
      done_off = valid ? 96 * (n_in + 2) : 0;
      n_strobe = 0; seq_err = 0; busy_err = 0; done_err = 0;
      if (valid) for (int o = 0; o < 96; o++) exp_q.push_back(DATSIZE'(ref_neuron(o, n_in, rl)));
      @(negedge clk);
      dif.start = 1'b1; dif.state = st; dif.relu = rl;
      @(negedge clk);
      dif.start = 1'b0;
      for (int off = 0; off <= done_off + 2; off++) begin
         if (off > 0) @(negedge clk);
         if (abort_off >= 0 && off == abort_off) begin
            #2 rst = 1'b1;
            #1 check({name, "_rst_outs"},
                     {dif.w_en, dif.read_o, dif.read_i, dif.act_addr, dif.out_valid,
                      dif.out_idx, dif.out_data, dif.busy, dif.done}, 0);
            check({name, "_rst_strobes"}, n_strobe, abort_off / (n_in + 2));
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (perturb && (off == 700 || off == 5000)) begin
            dif.start = 1'b1; dif.state = st ^ 4'b0001; dif.relu = ~rl;
         end else if (perturb && (off == 701 || off == 5001)) begin
            dif.start = 1'b0; dif.state = 4'b0010;
         end
         exp_wen = 1'b0; exp_ov = 1'b0; k = 0; p = 0;
         if (valid && off < done_off) begin
            k = off / (n_in + 2);
            p = off % (n_in + 2);
            exp_wen = (p < n_in);
            exp_ov  = (p == n_in + 1);
         end
         if (dif.w_en !== exp_wen || dif.out_valid !== exp_ov) seq_err++;
         if (exp_wen && (dif.read_i !== 8'(p) || dif.act_addr !== 8'(p) || dif.read_o !== 7'(k)))
            seq_err++;
         if (!(valid && off < done_off) && (dif.read_o !== 7'd0 || dif.read_i !== 8'd0))
            seq_err++;
         exp_busy = valid && off <= done_off;
         if (dif.busy !== exp_busy) busy_err++;
         if (dif.done !== (off == done_off)) done_err++;
         if (dif.out_valid === 1'b1) begin
            check({name, "_idx"}, dif.out_idx, n_strobe);
            if (exp_q.size() > 0) check({name, "_data"}, dif.out_data, exp_q.pop_front());
            n_strobe++;
         end
      end
      check({name, "_strobes"}, n_strobe, valid ? 96 : 0);
      check({name, "_seq"}, seq_err, 0);
      check({name, "_busy"}, busy_err, 0);
      check({name, "_done"}, done_err, 0);
   endtask

   initial begin
      dif.start = 1'b0; dif.state = 4'b0000; dif.relu = 1'b0;
      fill(0, 0, 0);
      repeat (3) @(negedge clk);
      check("reset_outs", {dif.w_en, dif.read_o, dif.read_i, dif.act_addr, dif.out_valid,
                           dif.out_idx, dif.out_data, dif.busy, dif.done}, 0);
      rst = 1'b0;

      run_layer("bad_state", 4'b0010, 1'b0, -1, 1'b0);

      fill(16384, 8192, 4096);
      run_layer("d1_const", 4'b1001, 1'b0, -1, 1'b0);
      check("d1_last_data", dif.out_data, 790528);

      fill(16384, -16384, 0);
      run_layer("d2_relu", 4'b1000, 1'b1, -1, 1'b0);
      run_layer("d2_sat_abort", 4'b1000, 1'b0, 40 * 258 + 100, 1'b0);

      for (int i = 0; i < 256; i++) act_mem[i] = DATSIZE'(int'($urandom_range(0, 65535)) - 32768);
      for (int o = 0; o < 96; o++) begin
         b_mem[o] = PARSIZE'($urandom_range(0, 65535));
         for (int i = 0; i < 256; i++) w_mem[o][i] = PARSIZE'($urandom_range(0, 65535));
      end
      run_layer("d1_rand", 4'b1001, 1'($urandom_range(0, 1)), -1, 1'b0);

      fill(0, 0, 0);
      for (int i = 0; i < 256; i++) act_mem[i] = DATSIZE'(i * 16384);
      w_mem[5][3] = 16'sd16384;
      for (int o = 0; o < 96; o++) b_mem[o] = (o == 5) ? 16'sd0 : PARSIZE'($urandom_range(0, 65535));
      check("d2_pick_model", ref_neuron(5, 256, 1'b0), 49152);
      run_layer("d2_pick_perturb", 4'b1000, 1'b0, -1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
